// File: rtl/shifter_stream_ctrl.sv
// Framed stream sequencer for a free-running tapped shifter: drives serial_in and the tap,
// and tags each shifter slot so only accepted samples are reported downstream.
module shifter_stream_ctrl #(
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned SHIFT_DEPTH = 8,
   parameter int unsigned LEN_WIDTH   = 16
) (
   input  logic                                                clk,
   input  logic                                                rstn,
   input  logic                                                start,
   input  logic [((SHIFT_DEPTH > 1) ? $clog2(SHIFT_DEPTH) : 1)-1:0] cfg_depth,
   input  logic [LEN_WIDTH-1:0]                                frame_len,
   input  logic                                                abort,
   input  logic [DATA_WIDTH-1:0]                               in_data,
   input  logic                                                in_valid,
   output logic                                                in_ready,
   output logic [DATA_WIDTH-1:0]                               sh_serial_in,
   output logic [((SHIFT_DEPTH > 1) ? $clog2(SHIFT_DEPTH) : 1)-1:0] sh_output_depth,
   input  logic [DATA_WIDTH-1:0]                               sh_depth_output,
   output logic [DATA_WIDTH-1:0]                               out_data,
   output logic                                                out_valid,
   output logic                                                out_last,
   output logic                                                busy,
   output logic                                                done
);

   localparam int unsigned DEPTH_W = (SHIFT_DEPTH > 1) ? $clog2(SHIFT_DEPTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [DEPTH_W-1:0]     depth_q, depth_d;
   logic [LEN_WIDTH-1:0]   len_q, len_d;
   logic [LEN_WIDTH-1:0]   in_cnt_q, in_cnt_d;
   logic [LEN_WIDTH-1:0]   out_cnt_q, out_cnt_d;
   logic [SHIFT_DEPTH-1:0] tag_q, tag_d;
   logic                   done_q, done_d;
   logic                   accept;

   // Datapath decode: tap and valid tag follow the latched depth for the whole frame
   assign in_ready        = (state_q == S_RUN);
   assign accept          = in_valid & in_ready;
   assign sh_serial_in    = accept ? in_data : '0;
   assign sh_output_depth = depth_q;
   assign out_data        = sh_depth_output;
   assign out_valid       = tag_q[depth_q];
   assign out_last        = out_valid & (out_cnt_q == (len_q - LEN_WIDTH'(1)));
   assign busy            = (state_q != S_IDLE);
   assign done            = done_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= S_IDLE;
         depth_q   <= '0;
         len_q     <= '0;
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
         tag_q     <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         depth_q   <= depth_d;
         len_q     <= len_d;
         in_cnt_q  <= in_cnt_d;
         out_cnt_q <= out_cnt_d;
         tag_q     <= tag_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      depth_d   = depth_q;
      len_d     = len_q;
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;
      tag_d     = SHIFT_DEPTH'({tag_q, accept});
      done_d    = 1'b0;

      if (out_valid) begin
         out_cnt_d = out_cnt_q + LEN_WIDTH'(1);
      end

      case (state_q)
         S_IDLE: begin
            // Leftover tags beyond the old tap must not leak into a deeper next frame
            tag_d     = '0;
            in_cnt_d  = '0;
            out_cnt_d = '0;
            if (start) begin
               if (frame_len != '0) begin
                  state_d = S_RUN;
                  depth_d = cfg_depth;
                  len_d   = frame_len;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (accept) begin
               in_cnt_d = in_cnt_q + LEN_WIDTH'(1);
               if ((in_cnt_q + LEN_WIDTH'(1)) == len_q) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (out_last) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort wins over everything; in-flight shifter data is masked by the cleared tags
      if (abort) begin
         state_d   = S_IDLE;
         tag_d     = '0;
         in_cnt_d  = '0;
         out_cnt_d = '0;
         done_d    = 1'b0;
      end
   end

endmodule

// File: tb/tb_shifter_stream_ctrl.sv
// Scoreboard bench for shifter_stream_ctrl with a behavioural shifter attached.
module tb_shifter_stream_ctrl;

   localparam int unsigned DW  = 16;
   localparam int unsigned SD  = 8;
   localparam int unsigned LW  = 16;
   localparam int unsigned DPW = 3;

   logic           clk = 1'b0;
   logic           rstn = 1'b0;
   logic           start = 1'b0;
   logic [DPW-1:0] cfg_depth = '0;
   logic [LW-1:0]  frame_len = '0;
   logic           abort = 1'b0;
   logic [DW-1:0]  in_data = '0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [DW-1:0]  sh_serial_in;
   logic [DPW-1:0] sh_output_depth;
   logic [DW-1:0]  sh_depth_output;
   logic [DW-1:0]  out_data;
   logic           out_valid;
   logic           out_last;
   logic           busy;
   logic           done;

   always #5 clk = ~clk;

   shifter_stream_ctrl #(.DATA_WIDTH(DW), .SHIFT_DEPTH(SD), .LEN_WIDTH(LW)) dut (
      .clk(clk), .rstn(rstn), .start(start), .cfg_depth(cfg_depth), .frame_len(frame_len),
      .abort(abort), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .sh_serial_in(sh_serial_in), .sh_output_depth(sh_output_depth),
      .sh_depth_output(sh_depth_output), .out_data(out_data), .out_valid(out_valid),
      .out_last(out_last), .busy(busy), .done(done)
   );

   // Free-running shifter: no reset, shifts every cycle
   logic [DW-1:0] sr [SD];
   initial for (int i = 0; i < SD; i++) sr[i] = '0;
   always @(posedge clk) begin
      sr[0] <= sh_serial_in;
      for (int i = 1; i < SD; i++) sr[i] <= sr[i-1];
   end
   assign sh_depth_output = sr[sh_output_depth];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int            cyc;
      logic [DW-1:0] data;
      logic          last;
   } exp_t;

   exp_t sbq[$];
   int   doneq[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever an output is due or presented
   logic mon_ev, mon_ed;
   always @(negedge clk) begin
      mon_ev = (sbq.size() > 0) && (sbq[0].cyc == cyc);
      mon_ed = (doneq.size() > 0) && (doneq[0] == cyc);
      if (out_valid || mon_ev) begin
         chk("out_valid", 32'(out_valid), 32'(mon_ev));
         if (out_valid && mon_ev) begin
            chk("out_data", 32'(out_data), 32'(sbq[0].data));
            chk("out_last", 32'(out_last), 32'(sbq[0].last));
         end
      end else if (out_last) begin
         chk("out_last_without_valid", 32'(out_last), 32'd0);
      end
      if (mon_ev) void'(sbq.pop_front());
      if (done || mon_ed) chk("done", 32'(done), 32'(mon_ed));
      if (mon_ed) void'(doneq.pop_front());
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         next_cycle();
         start    = 1'b0;
         abort    = 1'b0;
         in_valid = 1'($urandom);
         in_data  = DW'($urandom);
         @(negedge clk);
         chk("in_ready_idle", 32'(in_ready), 32'd0);
         chk("serial_in_idle", 32'(sh_serial_in), 32'd0);
      end
      next_cycle();
      in_valid = 1'b0;
      @(negedge clk);
      chk("busy_after", 32'(busy), 32'd0);
   endtask

   // mode 0: in_valid from pat bits (1 beyond bit 31); mode 1: random ~70%
   task automatic run_frame(input int depth, input int len, input int mode,
                            input logic [31:0] pat, input int abort_at, input bit mid_start);
      int   n;
      int   k;
      logic v;
      next_cycle();
      start     = 1'b1;
      cfg_depth = DPW'(depth);
      frame_len = LW'(len);
      in_valid  = 1'b0;
      if (len == 0) doneq.push_back(cyc + 1);
      @(negedge clk);
      if (len == 0) begin
         next_cycle();
         start = 1'b0;
         @(negedge clk);
         chk("busy_len0", 32'(busy), 32'd0);
         return;
      end
      n = 0;
      k = 0;
      while (n < len && k < 400) begin
         next_cycle();
         start     = mid_start && (k == 1);
         cfg_depth = start ? DPW'(5) : DPW'($urandom);
         frame_len = start ? LW'(9) : LW'($urandom);
         v = (mode != 0) ? ($urandom_range(99) < 70) : ((k < 32) ? pat[k] : 1'b1);
         abort = (n == abort_at);
         if (abort) v = 1'b0;
         in_valid = v;
         in_data  = DW'($urandom);
         @(negedge clk);
         chk("in_ready_run", 32'(in_ready), 32'd1);
         chk("busy_run", 32'(busy), 32'd1);
         chk("serial_in", 32'(sh_serial_in), v ? 32'(in_data) : 32'd0);
         chk("tap", 32'(sh_output_depth), 32'(depth));
         if (abort) begin
            while (sbq.size() > 0 && sbq[sbq.size()-1].cyc > cyc) void'(sbq.pop_back());
            doneq.delete();
            next_cycle();
            abort    = 1'b0;
            in_valid = 1'b0;
            @(negedge clk);
            chk("busy_abort", 32'(busy), 32'd0);
            chk("in_ready_abort", 32'(in_ready), 32'd0);
            idle_cycles(depth + 3);
            return;
         end
         if (v) begin
            sbq.push_back('{cyc + depth + 1, in_data, (n == len - 1)});
            if (n == len - 1) doneq.push_back(cyc + depth + 2);
            n++;
         end
         k++;
      end
      if (n < len) chk("accept_timeout", 32'(n), 32'(len));
      idle_cycles(depth + 2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int d;
      int l;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_serial_in", 32'(sh_serial_in), 32'd0);
      chk("rst_tap", 32'(sh_output_depth), 32'd0);
      next_cycle();
      rstn = 1'b1;
      idle_cycles(2);

      run_frame(3, 4, 0, 32'hFFFF_FFFF, -1, 1'b0);
      run_frame(0, 3, 0, 32'b1101, -1, 1'b0);
      run_frame(7, 1, 0, 32'hFFFF_FFFF, -1, 1'b0);
      run_frame(3, 5, 0, 32'hFFFF_FFFF, 2, 1'b0);
      run_frame(2, 2, 0, 32'hFFFF_FFFF, -1, 1'b0);
      run_frame(4, 0, 0, 32'hFFFF_FFFF, -1, 1'b0);
      run_frame(2, 6, 1, 32'h0, -1, 1'b1);

      // Reset in the middle of a frame
      next_cycle();
      start     = 1'b1;
      cfg_depth = DPW'(4);
      frame_len = LW'(6);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         start    = 1'b0;
         in_valid = 1'b1;
         in_data  = DW'($urandom);
         @(negedge clk);
         chk("in_ready_pre_rst", 32'(in_ready), 32'd1);
         sbq.push_back('{cyc + 5, in_data, 1'b0});
      end
      next_cycle();
      rstn     = 1'b0;
      in_valid = 1'b1;
      sbq.delete();
      doneq.delete();
      @(negedge clk);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_out_last", 32'(out_last), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_serial_in", 32'(sh_serial_in), 32'd0);
      next_cycle();
      rstn = 1'b1;
      idle_cycles(12);

      for (int f = 0; f < 25; f++) begin
         d = int'($urandom_range(SD - 1));
         l = int'($urandom_range(12, 1));
         run_frame(d, l, 1, 32'h0,
                   ($urandom_range(99) < 20) ? int'($urandom_range(l - 1)) : -1,
                   1'($urandom));
      end

      idle_cycles(SD + 2);
      chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
      chk("done_queue_empty", 32'(doneq.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
